// File: rtl/adc_pkg.sv
// Shared definitions for the ADC A/B pair aligner: sample width, FSM state
// encodings and a constant-evaluable ceil(log2) helper.
package adc_pkg;

    localparam int unsigned ADC_DW = 16;

    localparam logic [1:0] FLUSH = 2'd0;
    localparam logic [1:0] ALIGN = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;

    // ceil(log2(value)); usable in parameter and port-width expressions
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/adc_pair_buf.sv
// Single-channel circular sample buffer. Show-ahead read port (dout_c is the
// oldest entry), synchronous clear, and write-on-full accepted only when a
// read frees a slot in the same cycle.
module adc_pair_buf
    import adc_pkg::*;
#(
    parameter  int unsigned DEPTH = 8,
    parameter  int unsigned DW    = ADC_DW,
    localparam int unsigned AW    = clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          wr,
    input  logic [DW-1:0] din,
    input  logic          rd,
    output logic [DW-1:0] dout_c,
    output logic [CW-1:0] count,
    output logic          full_c,
    output logic          empty_c
);

    logic [DW-1:0] mem [DEPTH];
    logic [CW-1:0] wr_ptr;
    logic [CW-1:0] rd_ptr;
    logic          do_wr_c;
    logic          do_rd_c;

    // Pointer advance, wrapping modulo DEPTH
    function automatic logic [CW-1:0] ptr_inc(input logic [CW-1:0] ptr);
        return (ptr == CW'(DEPTH - 1)) ? '0 : ptr + CW'(1);
    endfunction

    // Effective read/write strobes and status flags
    always_comb begin
        full_c  = (count == CW'(DEPTH));
        empty_c = (count == '0);
        do_rd_c = rd && !empty_c && !clr;
        do_wr_c = wr && !clr && (!full_c || do_rd_c);
        dout_c  = mem[rd_ptr[AW-1:0]];
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr_c) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_rd_c) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CW'(do_wr_c) - CW'(do_rd_c);
        end
    end

    // Sample storage
    always_ff @(posedge clk) begin
        if (do_wr_c) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/adc_pair_aligner.sv
// Re-pairs independent A/B ADC sample streams into time-aligned pairs.
// Per-channel buffers absorb read-side skew; overflow or excessive skew
// triggers a one-cycle flush followed by re-alignment.
// Optional statistics outputs (pair_cnt, drop_cnt, skew_max) are built when
// the macro ADC_PAIR_STATS_EN is defined.
module adc_pair_aligner
    import adc_pkg::*;
#(
    parameter  int unsigned DEPTH    = 8,
    parameter  int unsigned MAX_SKEW = 4,
    parameter  int unsigned DW       = ADC_DW,
    localparam int unsigned CW       = clog2(DEPTH) + 1
) (
    input  logic          alg_clk,
    input  logic          alg_rst,
    input  logic [DW-1:0] data_in_A_channel,
    input  logic          data_in_A_channel_en,
    input  logic [DW-1:0] data_in_B_channel,
    input  logic          data_in_B_channel_en,
    input  logic          resync,
    output logic [DW-1:0] pair_A,
    output logic [DW-1:0] pair_B,
    output logic          pair_valid,
    output logic          overflow_err,
    output logic          skew_err,
`ifdef ADC_PAIR_STATS_EN
    output logic [31:0]   pair_cnt,
    output logic [15:0]   drop_cnt,
    output logic [CW-1:0] skew_max,
`endif
    output logic [1:0]    state_dbg
);

    logic [1:0]    state;
    logic [1:0]    state_nxt;

    logic [DW-1:0] a_dout_c;
    logic [DW-1:0] b_dout_c;
    logic [CW-1:0] a_count;
    logic [CW-1:0] b_count;
    logic          a_full_c;
    logic          b_full_c;
    logic          a_empty_c;
    logic          b_empty_c;

    logic          in_flush_c;
    logic          pair_rdy_c;
    logic          a_discard_c;
    logic          b_discard_c;
    logic          a_wr_c;
    logic          b_wr_c;
    logic          a_rd_c;
    logic          b_rd_c;
    logic          a_ovf_c;
    logic          b_ovf_c;
    logic          ovf_c;
    logic [CW-1:0] skew_diff_c;
    logic          skew_hit_c;

    // Per-channel buffers, cleared during the FLUSH cycle
    adc_pair_buf #(.DEPTH(DEPTH), .DW(DW)) u_buf_a (
        .clk     (alg_clk),
        .rst     (alg_rst),
        .clr     (in_flush_c),
        .wr      (a_wr_c),
        .din     (data_in_A_channel),
        .rd      (a_rd_c),
        .dout_c  (a_dout_c),
        .count   (a_count),
        .full_c  (a_full_c),
        .empty_c (a_empty_c)
    );

    adc_pair_buf #(.DEPTH(DEPTH), .DW(DW)) u_buf_b (
        .clk     (alg_clk),
        .rst     (alg_rst),
        .clr     (in_flush_c),
        .wr      (b_wr_c),
        .din     (data_in_B_channel),
        .rd      (b_rd_c),
        .dout_c  (b_dout_c),
        .count   (b_count),
        .full_c  (b_full_c),
        .empty_c (b_empty_c)
    );

    // State register
    always_ff @(posedge alg_clk) begin
        if (alg_rst) begin
            state <= FLUSH;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath strobes, error detection and next-state selection.
    // The ALIGN exit cycle already pops the first pair so that a pair
    // appears two cycles after the later of its two enables.
    always_comb begin
        in_flush_c  = (state == FLUSH);
        pair_rdy_c  = ((state == ALIGN) || (state == RUN)) && !a_empty_c && !b_empty_c;
        a_discard_c = (state == ALIGN) && (a_count >= CW'(MAX_SKEW + 1)) && b_empty_c;
        b_discard_c = (state == ALIGN) && (b_count >= CW'(MAX_SKEW + 1)) && a_empty_c;
        a_wr_c      = data_in_A_channel_en && !in_flush_c;
        b_wr_c      = data_in_B_channel_en && !in_flush_c;
        a_rd_c      = pair_rdy_c || a_discard_c;
        b_rd_c      = pair_rdy_c || b_discard_c;
        a_ovf_c     = a_wr_c && a_full_c && !a_rd_c;
        b_ovf_c     = b_wr_c && b_full_c && !b_rd_c;
        ovf_c       = a_ovf_c || b_ovf_c;
        skew_diff_c = (a_count >= b_count) ? (a_count - b_count) : (b_count - a_count);
        skew_hit_c  = (state == RUN) && (skew_diff_c > CW'(MAX_SKEW));

        state_nxt = state;
        case (state)
            FLUSH:   state_nxt = ALIGN;
            ALIGN:   if (!a_empty_c && !b_empty_c) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = FLUSH;
        endcase
        if (skew_hit_c || ovf_c || resync) begin
            state_nxt = FLUSH;
        end
    end

    // Registered pair output; data held between pairs
    always_ff @(posedge alg_clk) begin
        if (alg_rst) begin
            pair_A     <= '0;
            pair_B     <= '0;
            pair_valid <= 1'b0;
        end else begin
            pair_valid <= pair_rdy_c;
            if (pair_rdy_c) begin
                pair_A <= a_dout_c;
                pair_B <= b_dout_c;
            end
        end
    end

    // Sticky error flags; overflow outranks skew, resync clears both
    always_ff @(posedge alg_clk) begin
        if (alg_rst || resync) begin
            overflow_err <= 1'b0;
            skew_err     <= 1'b0;
        end else begin
            if (ovf_c) begin
                overflow_err <= 1'b1;
            end
            if (skew_hit_c && !ovf_c) begin
                skew_err <= 1'b1;
            end
        end
    end

    assign state_dbg = state;

`ifdef ADC_PAIR_STATS_EN
    logic [CW:0]   drop_inc_c;
    logic [16:0]   drop_sum_c;

    // Samples lost this cycle: flushed contents plus ignored enables, ALIGN
    // discards, or writes refused on a full buffer
    always_comb begin
        drop_inc_c = '0;
        if (in_flush_c) begin
            drop_inc_c = (CW+1)'(a_count) + (CW+1)'(b_count)
                       + (CW+1)'(data_in_A_channel_en) + (CW+1)'(data_in_B_channel_en);
        end else begin
            drop_inc_c = (CW+1)'(a_discard_c) + (CW+1)'(b_discard_c)
                       + (CW+1)'(a_ovf_c) + (CW+1)'(b_ovf_c);
        end
        drop_sum_c = 17'(drop_cnt) + 17'(drop_inc_c);
    end

    // Pair/drop counters and peak RUN skew
    always_ff @(posedge alg_clk) begin
        if (alg_rst || resync) begin
            pair_cnt <= '0;
            drop_cnt <= '0;
            skew_max <= '0;
        end else begin
            if (pair_rdy_c) begin
                pair_cnt <= pair_cnt + 32'd1;
            end
            drop_cnt <= drop_sum_c[16] ? 16'hFFFF : drop_sum_c[15:0];
            if ((state == RUN) && (skew_diff_c > skew_max)) begin
                skew_max <= skew_diff_c;
            end
        end
    end
`endif

endmodule
